// File: rtl/pie_cmd_framer.sv
`timescale 1ns/1ps
// pie_cmd_framer
// Upstream feeder for pie_encoder. Latches one reader command (payload of up
// to MAX_BITS bits, sent MSB-first). The payload is presented one bit at a
// time and advances on the encoder's in_rdy strobe. CRC-5 or CRC-16 is then
// appended. Between commands the encoder is held in reset. The block also
// drives the encoder's preamble select and a tx_active envelope.
//
// Ports
//   clk, rst_n     system clock, asynchronous active-low reset
//   cmd_start      1-cycle request, only looked at while idle
//   cmd_abort      synchronous abort, returns to idle from any state
//   cmd_bits       payload, left-justified (bit MAX_BITS-1 goes first)
//   cmd_len        payload bit count; anything above MAX_BITS is clamped
//   crc_mode       0 none, 1 CRC-5, 2 CRC-16, 3 none
//   cmd_preamble   1 full preamble (TRCAL), 0 frame-sync
//   cmd_busy       command in flight
//   cmd_done       1-cycle pulse on normal completion
//   tx_active      encoder output is a valid PIE frame
//   enc_rst        active-high reset to pie_encoder
//   enc_preamble   preamble select to pie_encoder
//   enc_bit        current head bit to pie_encoder
//   enc_rdy        pie_encoder consumes enc_bit in cycles where this is high
module pie_cmd_framer #(
    parameter int MAX_BITS = 128,
    parameter int LEN_W    = $clog2(MAX_BITS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_start,
    input  logic                cmd_abort,
    input  logic [MAX_BITS-1:0] cmd_bits,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic [1:0]          crc_mode,
    input  logic                cmd_preamble,
    output logic                cmd_busy,
    output logic                cmd_done,
    output logic                tx_active,
    output logic                enc_rst,
    output logic                enc_preamble,
    output logic                enc_bit,
    input  logic                enc_rdy
);

    typedef enum logic [1:0] {IDLE, PAYLOAD, CRC, DRAIN} state_t;

    localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(MAX_BITS);
    localparam logic [LEN_W-1:0] ONE       = LEN_W'(1);
    localparam logic [4:0]       CRC5_INIT = 5'b01001;

    state_t                state_q, state_d;
    logic [MAX_BITS-1:0]   shift_q, shift_d;
    logic [LEN_W-1:0]      remain_q, remain_d;
    logic [1:0]            mode_q, mode_d;
    logic [4:0]            crc5_q, crc5_d;
    logic [15:0]           crc16_q, crc16_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  txa_q, txa_d;
    logic                  erst_q, erst_d;
    logic                  epre_q, epre_d;

    logic                  head;
    logic [4:0]            crc5_step;
    logic [15:0]           crc16_step;
    logic [LEN_W-1:0]      len_clamped;
    logic [1:0]            start_mode;

    // Places the frozen CRC at the top of the shift register so that the
    // same MSB tap feeds the encoder for payload and for CRC.
    // CRC-16 goes out complemented. CRC-5 goes out as-is.
    function automatic logic [MAX_BITS-1:0] crc_image(input logic [1:0]  m,
                                                      input logic [4:0]  c5,
                                                      input logic [15:0] c16);
        crc_image = '0;
        if (m == 2'd1)
            crc_image[MAX_BITS-1 -: 5] = c5;
        else
            crc_image[MAX_BITS-1 -: 16] = ~c16;
    endfunction

    function automatic logic [LEN_W-1:0] crc_len(input logic [1:0] m);
        crc_len = (m == 2'd1) ? LEN_W'(5) : LEN_W'(16);
    endfunction

    // enc_bit is taken straight from a flop. It is never gated by enc_rdy.
    assign head = shift_q[MAX_BITS-1];

    // Bit-serial CRC update using the bit that the encoder is consuming
    always_comb begin
        crc5_step  = {crc5_q[3:0], 1'b0}  ^ ((head ^ crc5_q[4])   ? 5'b01001 : 5'b00000);
        crc16_step = {crc16_q[14:0], 1'b0} ^ ((head ^ crc16_q[15]) ? 16'h1021 : 16'h0000);
        len_clamped = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
        start_mode  = (crc_mode == 2'd1 || crc_mode == 2'd2) ? crc_mode : 2'd0;
    end

    // Next-state and next-output logic. Every output is the image of a flop,
    // so this block computes next values only.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        remain_d = remain_q;
        mode_d   = mode_q;
        crc5_d   = crc5_q;
        crc16_d  = crc16_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        txa_d    = txa_q;
        erst_d   = erst_q;
        epre_d   = epre_q;

        if (cmd_abort) begin
            state_d  = IDLE;
            shift_d  = '0;
            remain_d = '0;
            busy_d   = 1'b0;
            txa_d    = 1'b0;
            erst_d   = 1'b1;
            epre_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_start) begin
                        if (len_clamped == '0 && start_mode == 2'd0) begin
                            // Nothing to send. Acknowledge and stay idle.
                            done_d = 1'b1;
                        end else begin
                            busy_d  = 1'b1;
                            txa_d   = 1'b1;
                            erst_d  = 1'b0;
                            epre_d  = cmd_preamble;
                            mode_d  = start_mode;
                            crc5_d  = CRC5_INIT;
                            crc16_d = 16'hFFFF;
                            if (len_clamped != '0) begin
                                state_d  = PAYLOAD;
                                shift_d  = cmd_bits;
                                remain_d = len_clamped;
                            end else begin
                                state_d  = CRC;
                                shift_d  = crc_image(start_mode, CRC5_INIT, 16'hFFFF);
                                remain_d = crc_len(start_mode);
                            end
                        end
                    end
                end
                PAYLOAD: begin
                    if (enc_rdy) begin
                        crc5_d   = crc5_step;
                        crc16_d  = crc16_step;
                        shift_d  = {shift_q[MAX_BITS-2:0], 1'b0};
                        remain_d = remain_q - ONE;
                        if (remain_q == ONE) begin
                            if (mode_q != 2'd0) begin
                                state_d  = CRC;
                                shift_d  = crc_image(mode_q, crc5_step, crc16_step);
                                remain_d = crc_len(mode_q);
                            end else begin
                                state_d = DRAIN;
                                shift_d = '0;
                            end
                        end
                    end
                end
                CRC: begin
                    if (enc_rdy) begin
                        shift_d  = {shift_q[MAX_BITS-2:0], 1'b0};
                        remain_d = remain_q - ONE;
                        if (remain_q == ONE) begin
                            state_d = DRAIN;
                            shift_d = '0;
                        end
                    end
                end
                DRAIN: begin
                    // This strobe ends the final symbol. The encoder is put
                    // back into reset before it can start another symbol.
                    if (enc_rdy) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        txa_d   = 1'b0;
                        erst_d  = 1'b1;
                        epre_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            remain_q <= '0;
            mode_q   <= 2'd0;
            crc5_q   <= '0;
            crc16_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            txa_q    <= 1'b0;
            erst_q   <= 1'b1;
            epre_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            remain_q <= remain_d;
            mode_q   <= mode_d;
            crc5_q   <= crc5_d;
            crc16_q  <= crc16_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            txa_q    <= txa_d;
            erst_q   <= erst_d;
            epre_q   <= epre_d;
        end
    end

    assign enc_bit      = head;
    assign cmd_busy     = busy_q;
    assign cmd_done     = done_q;
    assign tx_active    = txa_q;
    assign enc_rst      = erst_q;
    assign enc_preamble = epre_q;

endmodule

// File: tb/tb_pie_cmd_framer.sv
`timescale 1ns/1ps
// tb_pie_cmd_framer
// Randomised bench for pie_cmd_framer. The reference model keeps the whole
// command as a queue of bits: payload followed by CRC. Each consume strobe
// pops one bit, and a further strobe on the empty queue ends the frame.
module tb_pie_cmd_framer;

    localparam int MAX_BITS = 128;
    localparam int LEN_W    = 8;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                cmd_start;
    logic                cmd_abort;
    logic [MAX_BITS-1:0] cmd_bits;
    logic [LEN_W-1:0]    cmd_len;
    logic [1:0]          crc_mode;
    logic                cmd_preamble;
    logic                cmd_busy;
    logic                cmd_done;
    logic                tx_active;
    logic                enc_rst;
    logic                enc_preamble;
    logic                enc_bit;
    logic                enc_rdy;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;
    int rdy_mode = 0;
    int done_cnt = 0;

    bit m_active = 1'b0;
    bit m_pre    = 1'b0;
    bit m_done   = 1'b0;
    bit m_q[$];
    bit seq_buf[$];
    bit dut_log[$];

    always #5 clk = ~clk;

    pie_cmd_framer #(.MAX_BITS(MAX_BITS), .LEN_W(LEN_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_start    (cmd_start),
        .cmd_abort    (cmd_abort),
        .cmd_bits     (cmd_bits),
        .cmd_len      (cmd_len),
        .crc_mode     (crc_mode),
        .cmd_preamble (cmd_preamble),
        .cmd_busy     (cmd_busy),
        .cmd_done     (cmd_done),
        .tx_active    (tx_active),
        .enc_rst      (enc_rst),
        .enc_preamble (enc_preamble),
        .enc_bit      (enc_bit),
        .enc_rdy      (enc_rdy)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Full bit sequence of a command: the clamped payload MSB-first, then the CRC
    function automatic void build_seq(input logic [127:0] b, input int len, input int mode);
        int n;
        int c5;
        int c16;
        int fb;
        seq_buf.delete();
        n   = (len > MAX_BITS) ? MAX_BITS : len;
        c5  = 5'h09;
        c16 = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            bit x;
            x = b[127 - i];
            seq_buf.push_back(x);
            fb  = int'(x) ^ ((c5 >> 4) & 1);
            c5  = (c5 << 1) & 31;
            if (fb != 0) c5 = c5 ^ 9;
            fb  = int'(x) ^ ((c16 >> 15) & 1);
            c16 = (c16 << 1) & 16'hFFFF;
            if (fb != 0) c16 = c16 ^ 16'h1021;
        end
        if (mode == 1) begin
            for (int i = 4; i >= 0; i--) seq_buf.push_back(bit'((c5 >> i) & 1));
        end else if (mode == 2) begin
            c16 = (~c16) & 16'hFFFF;
            for (int i = 15; i >= 0; i--) seq_buf.push_back(bit'((c16 >> i) & 1));
        end
    endfunction

    // Reference model
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_pre    = 1'b0;
            m_done   = 1'b0;
            m_q.delete();
        end else begin
            m_done = 1'b0;
            if (cmd_abort) begin
                m_active = 1'b0;
                m_q.delete();
            end else if (!m_active) begin
                if (cmd_start) begin
                    build_seq(cmd_bits, int'(cmd_len), int'(crc_mode));
                    if (seq_buf.size() == 0) begin
                        m_done = 1'b1;
                    end else begin
                        m_active = 1'b1;
                        m_pre    = cmd_preamble;
                        m_q      = seq_buf;
                    end
                end
            end else if (enc_rdy) begin
                if (m_q.size() > 0) void'(m_q.pop_front());
                else begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end
            end
        end
    end

    // Log of every bit the encoder consumed while the frame was active
    always @(posedge clk) begin
        if (rst_n && tx_active && enc_rdy) dut_log.push_back(enc_bit);
    end

    // Consume strobe: random, held high, or held low
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       enc_rdy = ($urandom_range(0, 1) == 1);
            1:       enc_rdy = 1'b1;
            default: enc_rdy = 1'b0;
        endcase
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        bit exp_bit;
        if (chk_en) begin
            exp_bit = (m_active && m_q.size() > 0) ? m_q[0] : 1'b0;
            checkOutput("enc_rst",      enc_rst,      !m_active);
            checkOutput("tx_active",    tx_active,    m_active);
            checkOutput("cmd_busy",     cmd_busy,     m_active);
            checkOutput("enc_preamble", enc_preamble, m_active & m_pre);
            checkOutput("enc_bit",      enc_bit,      exp_bit);
            checkOutput("cmd_done",     cmd_done,     m_done);
            if (cmd_done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [127:0] b, input int len, input int mode, input bit pre);
        cmd_bits     = b;
        cmd_len      = LEN_W'(len);
        crc_mode     = 2'(mode);
        cmd_preamble = pre;
        cmd_start    = 1'b1;
        tick();
        cmd_start    = 1'b0;
    endtask

    task automatic waitIdle(input int budget, input string name);
        int k;
        k = 0;
        while ((m_active || cmd_busy) && k < budget) begin
            tick();
            k++;
        end
        checkOutput(name, (k < budget) ? 32'd1 : 32'd0, 32'd1);
        tick();
    endtask

    function automatic logic [15:0] log_field(input int first, input int width);
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < width; i++) v = {v[14:0], dut_log[first + i]};
        return v;
    endfunction

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [127:0] ascii;
        logic [15:0]  v;
        int           d0;
        int           len;

        rst_n        = 1'b0;
        cmd_start    = 1'b0;
        cmd_abort    = 1'b0;
        cmd_bits     = '0;
        cmd_len      = '0;
        crc_mode     = 2'd0;
        cmd_preamble = 1'b0;
        enc_rdy      = 1'b0;
        ascii        = {72'h313233343536373839, 56'h0};

        // Pin the model with the standard check values
        build_seq(ascii, 72, 2);
        checkOutput("model crc16 length", seq_buf.size(), 88);
        v = '0;
        for (int i = 72; i < 88; i++) v = {v[14:0], seq_buf[i]};
        checkOutput("model crc16 value", v, 16'hD64E);
        build_seq(ascii, 72, 1);
        checkOutput("model crc5 length", seq_buf.size(), 77);
        v = '0;
        for (int i = 72; i < 77; i++) v = {v[14:0], seq_buf[i]};
        checkOutput("model crc5 value", v, 16'h0000);

        // Reset values
        tick();
        tick();
        chk_en = 1'b1;
        checkOutput("reset enc_rst", enc_rst, 1);
        checkOutput("reset tx_active", tx_active, 0);
        checkOutput("reset cmd_busy", cmd_busy, 0);
        checkOutput("reset enc_bit", enc_bit, 0);
        rst_n = 1'b1;
        tick();

        // Single-bit command without CRC and with the full preamble
        rdy_mode = 0;
        dut_log.delete();
        d0 = done_cnt;
        applyStimulus({1'b1, 127'h0}, 1, 0, 1'b1);
        checkOutput("len1 head bit", enc_bit, 1);
        checkOutput("len1 preamble", enc_preamble, 1);
        waitIdle(200, "len1 timeout");
        checkOutput("len1 strobes", dut_log.size(), 2);
        checkOutput("len1 first bit", dut_log[0], 1);
        checkOutput("len1 done count", done_cnt - d0, 1);

        // CRC-16 check string
        dut_log.delete();
        applyStimulus(ascii, 72, 2, 1'b0);
        waitIdle(1000, "crc16 timeout");
        checkOutput("crc16 strobes", dut_log.size(), 89);
        if (dut_log.size() >= 88) checkOutput("crc16 value", log_field(72, 16), 16'hD64E);
        else checkOutput("crc16 value", 0, 16'hD64E);

        // CRC-5 check string
        dut_log.delete();
        applyStimulus(ascii, 72, 1, 1'b1);
        waitIdle(1000, "crc5 timeout");
        checkOutput("crc5 strobes", dut_log.size(), 78);
        if (dut_log.size() >= 77) checkOutput("crc5 value", log_field(72, 5), 16'h0000);
        else checkOutput("crc5 value", 1, 16'h0000);

        // Abort in the middle of the payload, followed by a normal command
        rdy_mode = 1;
        d0 = done_cnt;
        applyStimulus({$urandom, $urandom, $urandom, $urandom}, 40, 0, 1'b1);
        repeat (10) tick();
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        checkOutput("abort enc_rst", enc_rst, 1);
        checkOutput("abort tx_active", tx_active, 0);
        tick();
        checkOutput("abort no done", done_cnt - d0, 0);
        rdy_mode = 0;
        applyStimulus({$urandom, $urandom, $urandom, $urandom}, 12, 1, 1'b0);
        checkOutput("after abort accepted", cmd_busy, 1);
        waitIdle(500, "after abort timeout");
        checkOutput("after abort done", done_cnt - d0, 1);

        // Oversized length, plus a second start while busy
        dut_log.delete();
        d0 = done_cnt;
        applyStimulus({$urandom, $urandom, $urandom, $urandom}, 200, 0, 1'b0);
        repeat (20) tick();
        applyStimulus({$urandom, $urandom, $urandom, $urandom}, 5, 2, 1'b1);
        waitIdle(2000, "clamp timeout");
        checkOutput("clamp strobes", dut_log.size(), 129);
        checkOutput("clamp done count", done_cnt - d0, 1);

        // Empty command without CRC
        applyStimulus('0, 0, 0, 1'b1);
        checkOutput("empty done", cmd_done, 1);
        checkOutput("empty enc_rst", enc_rst, 1);
        checkOutput("empty busy", cmd_busy, 0);
        tick();
        checkOutput("empty done clears", cmd_done, 0);

        // Asynchronous reset during the CRC phase
        rdy_mode = 1;
        applyStimulus({$urandom, $urandom, $urandom, $urandom}, 8, 2, 1'b1);
        repeat (12) tick();
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst enc_rst", enc_rst, 1);
        checkOutput("arst tx_active", tx_active, 0);
        checkOutput("arst cmd_busy", cmd_busy, 0);
        checkOutput("arst cmd_done", cmd_done, 0);
        checkOutput("arst enc_bit", enc_bit, 0);
        checkOutput("arst enc_preamble", enc_preamble, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Randomised commands with occasional aborts
        for (int n = 0; n < 40; n++) begin
            rdy_mode = int'($urandom_range(0, 1));
            len = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 140));
            applyStimulus({$urandom, $urandom, $urandom, $urandom}, len,
                          int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(1, 60)) tick();
                cmd_abort = 1'b1;
                tick();
                cmd_abort = 1'b0;
            end
            waitIdle(2000, "random timeout");
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
